// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the registered select and one-hot grant of the 8:1 mux.
// Optional forced release after MAX_HOLD grant cycles when MUX8_SCHED_TIMEOUT_EN is defined.
module mux8_rr_sched #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       grant_valid,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 31 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_params
        $error("mux8_rr_sched: MAX_HOLD/CNT_W out of range");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gv_q, gv_d;
    logic       natural_rel, release_now;
    logic [2:0] rot_ptr;
    logic [3:0] pick_idle, pick_rel;

    // Returns {found, index} of the first set bit scanning base, base+1, ... modulo 8.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = base + 3'(i);
            if (!res[3] && vec[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef MUX8_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic             forced;
    assign forced = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

    always_comb begin
        natural_rel = done || !req[sel_q];
`ifdef MUX8_SCHED_TIMEOUT_EN
        release_now = natural_rel || forced;
`else
        release_now = natural_rel;
`endif
        rot_ptr   = sel_q + 3'd1;
        pick_idle = rr_pick(req, ptr_q);
        // The releasing source is masked out so it cannot win its own release cycle.
        pick_rel  = rr_pick(req & ~(8'h01 << sel_q), rot_ptr);

        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        gv_d    = gv_q;
`ifdef MUX8_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pick_idle[3]) begin
                    sel_d   = pick_idle[2:0];
                    gnt_d   = 8'h01 << pick_idle[2:0];
                    gv_d    = 1'b1;
                    state_d = GRANT;
`ifdef MUX8_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d = rot_ptr;
`ifdef MUX8_SCHED_TIMEOUT_EN
                    to_d  = forced && !natural_rel;
                    cnt_d = '0;
`endif
                    if (pick_rel[3]) begin
                        sel_d = pick_rel[2:0];
                        gnt_d = 8'h01 << pick_rel[2:0];
                    end else begin
                        gnt_d   = '0;
                        gv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef MUX8_SCHED_TIMEOUT_EN
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            gv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            gv_q    <= gv_d;
        end
    end

`ifdef MUX8_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign sel         = sel_q;
    assign gnt         = gnt_q;
    assign grant_valid = gv_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: expected outputs queued per driven cycle, compared after the edge.
module tb_mux8_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       grant_valid;
    logic       timeout;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       gv;
        logic       to;
    } exp_t;

    exp_t sb[$];

    mux8_rr_sched #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .sel(sel),
        .gnt(gnt),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".sel"}, 32'(sel), 32'(e.sel));
        check({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        check({tag, ".gv"},  32'(grant_valid), 32'(e.gv));
        check({tag, ".to"},  32'(timeout), 32'(e.to));
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic d,
                        input logic [2:0] es, input logic [7:0] eg, input logic ev, input logic et);
        exp_t e;
        req  = r;
        done = d;
        sb.push_back('{sel: es, gnt: eg, gv: ev, to: et});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic do_reset();
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        check_outputs("reset", '{sel: 3'd0, gnt: 8'h00, gv: 1'b0, to: 1'b0});
        rst = 1'b0;

        // Asynchronous reset in the middle of a grant to source 5.
        step("rst_a", 8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0);
        step("rst_b", 8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outputs("rst_async", '{sel: 3'd0, gnt: 8'h00, gv: 1'b0, to: 1'b0});
        #1 rst = 1'b0;
        step("rst_c", 8'h01, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
        step("rst_d", 8'h01, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

        // Single request, release to idle keeps sel, done in idle is ignored.
        do_reset();
        step("single_a", 8'h08, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0);
        step("single_b", 8'h08, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        step("single_c", 8'h00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);

        // All requesting, done every second cycle: rotation 0..7 then wrap to 0.
        do_reset();
        step("rr_first", 8'hFF, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] cur;
            logic [2:0] nxt;
            cur = 3'(k);
            nxt = 3'(k + 1);
            step("rr_hold", 8'hFF, 1'b0, cur, 8'h01 << cur, 1'b1, 1'b0);
            step("rr_next", 8'hFF, 1'b1, nxt, 8'h01 << nxt, 1'b1, 1'b0);
        end
        step("rr_idle", 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

        // Releasing source 5 cannot re-win while still requesting.
        do_reset();
        step("excl_a", 8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0);
        step("excl_b", 8'hA0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0);
        step("excl_c", 8'hA0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
        step("excl_d", 8'h00, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);

        // Release by dropping req without done.
        do_reset();
        step("drop_a", 8'h04, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0);
        step("drop_b", 8'h10, 1'b0, 3'd4, 8'h10, 1'b1, 1'b0);
        step("drop_c", 8'h00, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0);

        // Long hold by source 1 with source 2 waiting.
        do_reset();
        step("hold_a", 8'h02, 1'b0, 3'd1, 8'h02, 1'b1, 1'b0);
`ifdef MUX8_SCHED_TIMEOUT_EN
        for (int k = 0; k < 3; k++)
            step("hold_b", 8'h06, 1'b0, 3'd1, 8'h02, 1'b1, 1'b0);
        step("hold_to", 8'h06, 1'b0, 3'd2, 8'h04, 1'b1, 1'b1);
        step("hold_after", 8'h06, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0);
`else
        for (int k = 0; k < 20; k++)
            step("hold_b", 8'h06, 1'b0, 3'd1, 8'h02, 1'b1, 1'b0);
        step("hold_rel", 8'h06, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
`endif
        step("hold_end", 8'h00, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
